izh_neuron_array: RTL and testbench

- Time-multiplexed array of N Izhikevich neurons sharing one fixed-point datapath.
- Each sweep updates every neuron by one Euler step.
- Per-neuron behaviour preset (RS/IB/CH/FS/TC/RZ/LTS) and per-neuron input current.
- Sits between the tile I/O shim (config writes, start) and spike/probe outputs; successor to the single hard-wired neuron.

---
 rtl/izh_neuron_array_if.sv | 33 +++
 rtl/izh_neuron_array.sv | 250 +++++++++++++++++++++++++
 tb/tb_izh_neuron_array.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/izh_neuron_array_if.sv
// izh_neuron_array_if: start/done handshake, config writes, spikes and probe
// of one neuron array; master is the tile shim, slave is the array.
interface izh_neuron_array_if #(
  parameter int N = 4,
  parameter int W = 18
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic                start;
  logic                busy;
  logic                done;
  logic                cfg_we;
  logic [AW-1:0]       cfg_addr;
  logic [2:0]          cfg_mode;
  logic signed [W-1:0] cfg_current;
  logic                cfg_reinit;
  logic [N-1:0]        spike;
  logic [AW-1:0]       probe_sel;
  logic signed [W-1:0] probe_v;
  logic [15:0]         spike_cnt;

  modport master (
    output start, cfg_we, cfg_addr, cfg_mode,
    output cfg_current, cfg_reinit, probe_sel,
    input  busy, done, spike, probe_v, spike_cnt
  );

  modport slave (
    input  start, cfg_we, cfg_addr, cfg_mode,
    input  cfg_current, cfg_reinit, probe_sel,
    output busy, done, spike, probe_v, spike_cnt
  );
endinterface

// File: rtl/izh_neuron_array.sv
// izh_neuron_array: N Izhikevich neurons on one shared fixed-point datapath.
// Define IZH_REFRACTORY_EN to add per-neuron refractory counters.
module izh_neuron_array #(
  parameter int N            = 4,
  parameter int W            = 18,
  parameter int FRAC         = 9,
  parameter int DT_SHIFT     = 4,
  parameter int REFRAC_STEPS = 3
) (
  input logic               clk,
  input logic               rst,
  izh_neuron_array_if.slave bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = W + 2;
  localparam int PW = 2 * W;
  localparam int RW =
    (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  function automatic int q(real x);
    real s;
    s = x * real'(1 << FRAC);
    return (s < 0.0) ? -$rtoi(0.5 - s) : $rtoi(s + 0.5);
  endfunction

  localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] C04  = W'(q(0.04));
  localparam logic signed [W-1:0] K5   = W'(q(5.0));
  localparam logic signed [W-1:0] K140 = W'(q(140.0));
  localparam logic signed [W-1:0] THR  = W'(q(30.0));
  localparam logic signed [W-1:0] A02  = W'(q(0.02));
  localparam logic signed [W-1:0] A10  = W'(q(0.1));
  localparam logic signed [W-1:0] B20  = W'(q(0.2));
  localparam logic signed [W-1:0] B25  = W'(q(0.25));
  localparam logic signed [W-1:0] C65  = W'(q(-65.0));
  localparam logic signed [W-1:0] C55  = W'(q(-55.0));
  localparam logic signed [W-1:0] C50  = W'(q(-50.0));
  localparam logic signed [W-1:0] D8   = W'(q(8.0));
  localparam logic signed [W-1:0] D4   = W'(q(4.0));
  localparam logic signed [W-1:0] D2   = W'(q(2.0));
  localparam logic signed [W-1:0] D005 = W'(q(0.05));

  typedef struct packed {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] c;
    logic signed [W-1:0] d;
  } preset_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, CALC, WB, FIN
  } state_t;

  function automatic preset_t preset(input logic [2:0] m);
    preset_t p;
    case (m)
      3'd1:    p = '{A02, B20, C55, D4};
      3'd2:    p = '{A02, B20, C50, D2};
      3'd3:    p = '{A10, B20, C65, D2};
      3'd4:    p = '{A02, B25, C65, D005};
      3'd5:    p = '{A10, B25, C65, D2};
      3'd6:    p = '{A02, B25, C65, D2};
      default: p = '{A02, B20, C65, D8};
    endcase
    return p;
  endfunction

  function automatic logic signed [W-1:0] c_of(
    input logic [2:0] m
  );
    preset_t p;
    p = preset(m);
    return p.c;
  endfunction

  // Full-width product, floor shift, then clamp.
  function automatic logic signed [W-1:0] mul_q(
    input logic signed [W-1:0] x,
    input logic signed [W-1:0] y
  );
    logic signed [PW-1:0] p;
    p = (PW'(x) * PW'(y)) >>> FRAC;
    if (p[PW-1:W-1] == '0 || p[PW-1:W-1] == '1)
      return p[W-1:0];
    return p[PW-1] ? MINV : MAXV;
  endfunction

  function automatic logic signed [W-1:0] add_s(
    input logic signed [W-1:0] x,
    input logic signed [W-1:0] y,
    input logic                sub
  );
    logic signed [XW-1:0] s;
    s = sub ? XW'(x) - XW'(y) : XW'(x) + XW'(y);
    if (s[XW-1:W-1] == '0 || s[XW-1:W-1] == '1)
      return s[W-1:0];
    return s[XW-1] ? MINV : MAXV;
  endfunction

  state_t state, state_n;

  logic signed [W-1:0] v_mem    [N];
  logic signed [W-1:0] u_mem    [N];
  logic [2:0]          mode_sh  [N];
  logic [2:0]          mode_act [N];
  logic signed [W-1:0] cur_sh   [N];
  logic signed [W-1:0] cur_act  [N];

  logic [AW-1:0]       k;
  logic signed [W-1:0] v_r, u_r, cur_r;
  logic signed [W-1:0] vsq_r, au_r;
  preset_t             pr;
  logic [N-1:0]        pend;

  logic                accept, last, cfg_ok, hold, fire;
  logic signed [W-1:0] bmu, dv, v_new, u_new;
  logic [16:0]         cnt_sum;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (k == AW'(N - 1));
  assign cfg_ok = bus.cfg_we && (int'(bus.cfg_addr) < N);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = LOAD;
      LOAD:    state_n = CALC;
      CALC:    state_n = WB;
      WB:      state_n = last ? FIN : LOAD;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == FIN);
  end

  // dv chain: 0.04*v^2 + 5v + 140 - u + I, clamped at every add.
  always_comb begin
    bmu   = add_s(mul_q(pr.b, v_r), u_r, 1'b1);
    dv    = add_s(mul_q(C04, vsq_r), mul_q(K5, v_r), 1'b0);
    dv    = add_s(dv, K140, 1'b0);
    dv    = add_s(dv, u_r, 1'b1);
    dv    = add_s(dv, cur_r, 1'b0);
    v_new = add_s(v_r, dv >>> DT_SHIFT, 1'b0);
    u_new = add_s(u_r, au_r >>> DT_SHIFT, 1'b0);
    fire  = (v_r >= THR);
    cnt_sum = {1'b0, bus.spike_cnt} + 17'($countones(pend));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        v_mem[i]    <= C65;
        u_mem[i]    <= '0;
        mode_sh[i]  <= '0;
        mode_act[i] <= '0;
        cur_sh[i]   <= '0;
        cur_act[i]  <= '0;
      end
      k             <= '0;
      v_r           <= '0;
      u_r           <= '0;
      cur_r         <= '0;
      vsq_r         <= '0;
      au_r          <= '0;
      pr            <= '0;
      pend          <= '0;
      bus.spike     <= '0;
      bus.spike_cnt <= '0;
      bus.probe_v   <= '0;
    end else begin
      if (cfg_ok) begin
        mode_sh[bus.cfg_addr] <= bus.cfg_mode;
        cur_sh[bus.cfg_addr]  <= bus.cfg_current;
        if (bus.cfg_reinit && state == IDLE) begin
          v_mem[bus.cfg_addr] <= c_of(bus.cfg_mode);
          u_mem[bus.cfg_addr] <= '0;
        end
      end
      if (accept) begin
        k        <= '0;
        mode_act <= mode_sh;
        cur_act  <= cur_sh;
      end
      if (state == LOAD) begin
        v_r   <= v_mem[k];
        u_r   <= u_mem[k];
        cur_r <= cur_act[k];
        pr    <= preset(mode_act[k]);
      end
      if (state == CALC) begin
        vsq_r <= mul_q(v_r, v_r);
        au_r  <= mul_q(pr.a, bmu);
      end
      if (state == WB) begin
        if (hold) begin
          v_mem[k] <= pr.c;
          pend[k]  <= 1'b0;
        end else if (fire) begin
          v_mem[k] <= pr.c;
          u_mem[k] <= add_s(u_r, pr.d, 1'b0);
          pend[k]  <= 1'b1;
        end else begin
          v_mem[k] <= v_new;
          u_mem[k] <= u_new;
          pend[k]  <= 1'b0;
        end
        if (!last) k <= k + 1'b1;
      end
      if (state == FIN) begin
        bus.spike     <= pend;
        bus.spike_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
      end
      bus.probe_v <= (int'(bus.probe_sel) < N) ?
                     v_mem[bus.probe_sel] : '0;
    end
  end

`ifdef IZH_REFRACTORY_EN
  logic [RW-1:0] ref_cnt [N];

  assign hold = (ref_cnt[k] != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) ref_cnt[i] <= '0;
    end else begin
      if (cfg_ok && bus.cfg_reinit && state == IDLE)
        ref_cnt[bus.cfg_addr] <= '0;
      if (state == WB) begin
        if (hold)      ref_cnt[k] <= ref_cnt[k] - 1'b1;
        else if (fire) ref_cnt[k] <= RW'(REFRAC_STEPS);
      end
    end
  end
`else
  logic [RW-1:0] unused_ref;
  assign hold       = 1'b0;
  assign unused_ref = '0;
`endif
endmodule

// File: tb/tb_izh_neuron_array.sv
// tb_izh_neuron_array: directed vectors for izh_neuron_array, with an
// integer reference of the Q9.9 array state for multi-sweep runs.
module tb_izh_neuron_array;
  localparam int N   = 4;
  localparam int W   = 18;
  localparam int CRS = -33280;
`ifdef IZH_REFRACTORY_EN
  localparam int MREF = 3;
`else
  localparam int MREF = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  izh_neuron_array_if #(.N(N), .W(W)) bus ();

  izh_neuron_array #(
    .N(N), .W(W), .FRAC(9), .DT_SHIFT(4), .REFRAC_STEPS(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Preset tables in LSBs (index 7 behaves as RS).
  int pa[8] = '{10, 10, 10, 51, 10, 51, 10, 10};
  int pb[8] = '{102, 102, 102, 102, 128, 128, 128, 102};
  int pc[8] = '{-33280, -28160, -25600, -33280,
                -33280, -33280, -33280, -33280};
  int pd[8] = '{4096, 2048, 1024, 1024, 26, 1024, 1024, 4096};

  int mv[N], mu[N], mm[N], mi[N], sm[N], si[N], mref[N];
  logic [N-1:0] mspk;
  int mcnt;
  int cf_a, cf_m, cf_i;
  bit cf_r;

  function automatic int sat(input longint x);
    if (x > 131071)  return 131071;
    if (x < -131072) return -131072;
    return int'(x);
  endfunction

  function automatic int qm(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return sat(p >>> 9);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = CRS; mu[i] = 0; mm[i] = 0; mi[i] = 0;
      sm[i] = 0; si[i] = 0; mref[i] = 0;
    end
    mspk = '0;
    mcnt = 0;
  endtask

  task automatic model_sweep();
    int v, u, dv, au;
    mm = sm;
    mi = si;
    for (int i = 0; i < N; i++) begin
      v = mv[i];
      u = mu[i];
      mspk[i] = 1'b0;
      if (mref[i] > 0) begin
        mv[i] = pc[mm[i]];
        mref[i]--;
      end else if (v >= 15360) begin
        mv[i] = pc[mm[i]];
        mu[i] = sat(u + pd[mm[i]]);
        mspk[i] = 1'b1;
        mref[i] = MREF;
      end else begin
        dv = sat(qm(20, qm(v, v)) + qm(2560, v));
        dv = sat(dv + 71680);
        dv = sat(dv - u);
        dv = sat(dv + mi[i]);
        au = qm(pa[mm[i]], sat(qm(pb[mm[i]], v) - u));
        mv[i] = sat(v + (dv >>> 4));
        mu[i] = sat(u + (au >>> 4));
      end
    end
    mcnt = mcnt + $countones(mspk);
    if (mcnt > 65535) mcnt = 65535;
  endtask

  task automatic probe_one(input int i, output int v);
    bus.probe_sel = 2'(i);
    @(posedge clk); #1;
    v = int'(bus.probe_v);
  endtask

  task automatic probe_all(input string tag);
    int v;
    for (int i = 0; i < N; i++) begin
      probe_one(i, v);
      check($sformatf("%s_v%0d", tag, i), v, mv[i]);
    end
  endtask

  task automatic cfg_idle(input int a, input int m,
                          input int cur, input bit ri);
    bus.cfg_we      = 1'b1;
    bus.cfg_addr    = 2'(a);
    bus.cfg_mode    = 3'(m);
    bus.cfg_current = 18'(cur);
    bus.cfg_reinit  = ri;
    @(posedge clk); #1;
    bus.cfg_we     = 1'b0;
    bus.cfg_reinit = 1'b0;
    sm[a] = m;
    si[a] = cur;
    if (ri) begin
      mv[a] = pc[m]; mu[a] = 0; mref[a] = 0;
    end
  endtask

  // Sample c is taken #1 after the (c-1)-th edge past the accept edge.
  task automatic run_sweep(input string tag, input int restart_at,
                           input int cfg_at, input int rst_at);
    int nbusy, ndone, done_at;
    nbusy = 0; ndone = 0; done_at = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (rst_at == 0) model_sweep();
    for (int c = 1; c <= 40; c++) begin
      if (bus.busy) nbusy++;
      if (bus.done) begin
        ndone++;
        done_at = c;
      end
      if (c == restart_at) bus.start = 1'b1;
      if (c == cfg_at) begin
        bus.cfg_we      = 1'b1;
        bus.cfg_addr    = 2'(cf_a);
        bus.cfg_mode    = 3'(cf_m);
        bus.cfg_current = 18'(cf_i);
        bus.cfg_reinit  = cf_r;
        sm[cf_a] = cf_m;
        si[cf_a] = cf_i;
      end
      if (c == rst_at) rst = 1'b0;
      @(posedge clk); #1;
      bus.start      = 1'b0;
      bus.cfg_we     = 1'b0;
      bus.cfg_reinit = 1'b0;
      rst            = 1'b1;
    end
    if (rst_at != 0) begin
      model_reset();
      check({tag, "_busy_cycles"}, nbusy, rst_at);
      check({tag, "_dones"}, ndone, 0);
    end else begin
      check({tag, "_busy_cycles"}, nbusy, 13);
      check({tag, "_dones"}, ndone, 1);
      check({tag, "_done_at"}, done_at, 13);
    end
    check({tag, "_spike"}, bus.spike, mspk);
    check({tag, "_cnt"}, bus.spike_cnt, mcnt);
  endtask

  initial begin
    int v;
    bit found;
    bus.start       = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_addr    = '0;
    bus.cfg_mode    = '0;
    bus.cfg_current = '0;
    bus.cfg_reinit  = 1'b0;
    bus.probe_sel   = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_spike", bus.spike, 0);
    check("rst_cnt", bus.spike_cnt, 0);
    check("rst_probe", bus.probe_v, 0);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      probe_one(i, v);
      check($sformatf("rst_v%0d", i), v, CRS);
    end

    // RS, I=0 from -65: 5119-131072+71680 = -54273, >>>4 = -3393.
    run_sweep("sw1", 5, 0, 0);
    probe_one(0, v);
    check("sw1_v0_hand", v, -36673);
    probe_all("sw1");

    cfg_idle(1, 0, 131071, 1'b1);
    found = 1'b0;
    for (int s = 0; s < 60 && !found; s++) begin
      run_sweep($sformatf("drv%0d", s), 0, 0, 0);
      probe_one(1, v);
      check($sformatf("drv%0d_v1", s), v, mv[1]);
      if (mspk[1]) begin
        found = 1'b1;
        check("spk_flag1", bus.spike[1], 1);
        check("spk_v1_reset", v, CRS);
      end
    end
    check("spk_seen", found, 1);
    run_sweep("post_spk", 0, 0, 0);
    probe_all("post_spk");

    cf_a = 2; cf_m = 3; cf_i = 5120; cf_r = 1'b1;
    run_sweep("midcfg", 0, 5, 0);
    probe_all("midcfg");
    run_sweep("fs", 0, 0, 0);
    probe_all("fs");

`ifdef IZH_REFRACTORY_EN
    cfg_idle(3, 0, 131071, 1'b1);
    found = 1'b0;
    for (int s = 0; s < 60 && !found; s++) begin
      run_sweep($sformatf("rdrv%0d", s), 0, 0, 0);
      if (mspk[3]) found = 1'b1;
    end
    check("ref_spk_seen", found, 1);
    for (int h = 1; h <= 3; h++) begin
      run_sweep($sformatf("ref_hold%0d", h), 0, 0, 0);
      check($sformatf("ref_hold%0d_spk3", h), bus.spike[3], 0);
      probe_one(3, v);
      check($sformatf("ref_hold%0d_v3", h), v, CRS);
    end
    run_sweep("ref_resume", 0, 0, 0);
    probe_one(3, v);
    check("ref_resume_v3", v, mv[3]);
    check("ref_resume_moved", v != CRS, 1);
`endif

    run_sweep("abort", 0, 0, 5);
    check("abort_busy", bus.busy, 0);
    probe_all("abort");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
